// File: rtl/segments2dcba_reader_pkg.sv
// segments2dcba_reader_pkg
// Shared definitions for the 7-segment read-back path.
//   - SEG_0 .. SEG_F : active-low glyph patterns, bit6=a .. bit0=g, same
//                      bit order as the forward hex-to-segment encoder.
//   - SEG_BLANK      : all segments off.
//   - state_t        : qualifier FSM states used by the reader.
package segments2dcba_reader_pkg;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // WAIT  : sampled anodes are not one-hot-low, nothing can be captured
  // DWELL : one-hot-low anodes, still qualifying the pattern
  // HELD  : pattern already captured for this dwell
  typedef enum logic [1:0] {
    WAIT,
    DWELL,
    HELD
  } state_t;

endpackage

// File: rtl/segments2dcba_reader_lut.sv
// segments2dcba_lut
// Purely combinational inverse of the hex-to-7-segment encoder.
// Ports:
//   pattern : in  7  active-low segment pattern (bit6=a .. bit0=g)
//   nibble  : out 4  decoded hex digit, 0 when the pattern is not a glyph
//   err     : out 1  high when the pattern matches none of the 16 glyphs
module segments2dcba_lut
  import segments2dcba_reader_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       err
);

  // Exact match against the glyph table; anything else (blank included)
  // is flagged and reported as nibble 0.
  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/segments2dcba_reader.sv
// segments2dcba_reader
// Observes a multiplexed active-low 7-segment bus and rebuilds the hex word
// being displayed. A digit is captured once its anode/segment pattern has
// been stable for STABLE_CYCLES consecutive edges; when every digit has been
// captured the assembled word is published with a one-cycle valid pulse.
// Ports:
//   clk       : in  1         rising-edge clock
//   rst_n     : in  1         synchronous active-low reset
//   segments  : in  7         active-low segments, bit6=a .. bit0=g
//   anodes    : in  DIGITS    active-low digit enables, bit i = digit i
//   value     : out 4*DIGITS  last completed frame, digit i at [4i+3:4i]
//   valid     : out 1         pulses when value/digit_err update
//   digit_err : out DIGITS    per-digit illegal-glyph flags of that frame
module segments2dcba_reader
  import segments2dcba_reader_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            segments,
  input  logic [DIGITS-1:0]     anodes,
  output logic [4*DIGITS-1:0]   value,
  output logic                  valid,
  output logic [DIGITS-1:0]     digit_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [DIGITS-1:0]   s_an;
  logic [6:0]          s_seg;
  logic [CW-1:0]       cnt;
  state_t              state, state_nx;

  logic [4*DIGITS-1:0] slots, slots_nx;
  logic [DIGITS-1:0]   errs, errs_nx;
  logic [DIGITS-1:0]   seen, seen_nx;

  logic                changed;
  logic                in_onehot;
  logic [DIGITS-1:0]   in_en;
  logic [IW-1:0]       idx;
  logic [3:0]          dec_nibble;
  logic                dec_err;
  logic                capture;
  logic                frame_done;

  segments2dcba_lut u_lut (
    .pattern (s_seg),
    .nibble  (dec_nibble),
    .err     (dec_err)
  );

  // Change detection against the sample register, plus a one-hot-low test
  // on the incoming anodes to choose DWELL or WAIT when a new pattern lands.
  always_comb begin
    changed   = ({anodes, segments} != {s_an, s_seg});
    in_en     = ~anodes;
    in_onehot = (in_en != '0) && ((in_en & (in_en - DIGITS'(1))) == '0);
  end

  // Digit index of the single low bit of the sampled anodes. Only consulted
  // in DWELL, where the sample is known to be one-hot-low.
  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!s_an[i]) idx = IW'(i);
    end
  end

  // Capture fires on the edge the counter would reach STABLE_CYCLES while
  // the inputs still match the sample. The counter saturates, so a digit
  // held forever is only captured once; HELD makes that explicit.
  always_comb begin
    capture  = (state == DWELL) && !changed && (cnt == CNT_LAST);
    state_nx = state;
    if (changed) begin
      state_nx = in_onehot ? DWELL : WAIT;
    end else if (capture) begin
      state_nx = HELD;
    end
  end

  // Next contents of the slot/err/seen arrays. The frame completes on the
  // edge whose capture fills the last unseen digit, so the published word
  // must include that capture.
  always_comb begin
    slots_nx = slots;
    errs_nx  = errs;
    seen_nx  = seen;
    if (capture) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx == IW'(i)) begin
          slots_nx[4*i +: 4] = dec_nibble;
          errs_nx[i]         = dec_err;
          seen_nx[i]         = 1'b1;
        end
      end
    end
    frame_done = capture && (&seen_nx);
  end

  // All state and outputs are registered here. A reset discards partially
  // collected frames by clearing seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_an      <= '1;
      s_seg     <= SEG_BLANK;
      cnt       <= '0;
      state     <= WAIT;
      slots     <= '0;
      errs      <= '0;
      seen      <= '0;
      value     <= '0;
      valid     <= 1'b0;
      digit_err <= '0;
    end else begin
      if (changed) begin
        s_an  <= anodes;
        s_seg <= segments;
        cnt   <= CW'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      state <= state_nx;
      slots <= slots_nx;
      errs  <= errs_nx;
      valid <= frame_done;
      if (frame_done) begin
        value     <= slots_nx;
        digit_err <= errs_nx;
        seen      <= '0;
      end else begin
        seen <= seen_nx;
      end
    end
  end

endmodule

// File: doc/segments2dcba_reader.md
# segments2dcba_reader

Reads back a time-multiplexed, active-low 7-segment display bus (digit anodes plus shared segment lines) and recovers the hex value being shown. Each digit's segment pattern is decoded back to its nibble, and the four digits are assembled into one word. The block qualifies every pattern by requiring it to be stable for a set number of cycles. It sits on the observation side of the display path and lets the board or bench confirm what the driver is actually displaying.

## Interface
Parameters:
- DIGITS, 4, number of multiplexed digits; value width is 4*DIGITS.
- STABLE_CYCLES, 4, consecutive identical samples needed before a capture; legal range is ≥2.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- segments  input  7  active-low segment lines; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- anodes  input  DIGITS  active-low digit enables; bit i selects digit i, and digit 0 is the least significant nibble.
- value  output  4*DIGITS  last completed frame; digit i sits at bits [4i+3:4i].
- valid  output  1  one-cycle pulse when value and digit_err update.
- digit_err  output  DIGITS  per-digit flag for the last frame: the captured pattern was not a legal glyph.

## Operation
- Decode table (pattern → nibble):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3
  - 1001100→4, 0100100→5, 0100000→6, 0001111→7
  - 0000000→8, 0000100→9, 0001000→A, 1100000→b
  - 0110001→C, 1000010→d, 0110000→E, 0111000→F
  - Any other pattern, including blank 1111111, decodes to nibble 0 with err=1.
- Sample register {s_an, s_seg}:
  - Each clock, if {anodes, segments} differs from the sample register, load it and set cnt=1.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- Qualifier FSM:
  - WAIT: the sampled anode vector is not one-hot-low (zero or several digits enabled). cnt still runs, but nothing is captured. A change to a one-hot-low anode vector goes to DWELL.
  - DWELL: one-hot-low anodes with cnt<STABLE_CYCLES. When cnt reaches STABLE_CYCLES with inputs still equal to the sample, capture and go to HELD. Any input change returns to DWELL (new one-hot) or WAIT.
  - HELD: the pattern has already been captured and no further capture happens. Any input change leaves HELD via the DWELL/WAIT rule.
- Capture: slot[idx]←decoded nibble, err[idx]←decode error, seen[idx]←1, where idx is the index of the single low anode bit.
- Recapturing a digit before the frame completes overwrites its slot and err; the latest capture wins.
- Frame completion: on the edge where seen becomes all-ones (including the capture on that same edge):
  - value←slots, digit_err←errs, valid←1.
  - seen cleared to 0; slot/err contents are kept but are overwritten by later captures.
- valid is 0 on every other cycle.
- Reset (rst_n=0 at an edge): value=0, valid=0, digit_err=0, seen=0, cnt=0, sample register=all ones, FSM=WAIT.
- Reset mid-frame discards any partial captures.

## Timing
- Capture latency: inputs held constant at edges k..k+STABLE_CYCLES−1 are captured at edge k+STABLE_CYCLES−1.
- A single-cycle glitch inside a dwell restarts qualification and costs at least STABLE_CYCLES more cycles.
- Output latency: value, digit_err and valid update on the same edge as the completing capture and are visible the following cycle. valid is high for exactly one cycle.
- Throughput: one capture per dwell. Minimum frame time is DIGITS×STABLE_CYCLES cycles.
- A digit held indefinitely is captured once and never completes a frame on its own.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - the 16 glyph constants as 7-bit localparams, in the same bit order as the forward encoder;
  - SEG_BLANK = 7'b1111111;
  - the FSM state enum {WAIT, DWELL, HELD}.
- Sub-module segments2dcba_lut: purely combinational, 7-bit pattern in, 4-bit nibble plus err out. It is reused by the reader and by benches.
- Top level: sample register, saturating counter, FSM, one-hot index encoder, slot/err/seen arrays, output registers.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs → value=0, valid=0, digit_err=0 throughout; no capture after release until a full dwell.
- Clean frame: STABLE_CYCLES=4; drive digits 0..3 with glyphs 4, 3, 2, 1 for 4 cycles each → a single valid pulse, value=16'h1234, digit_err=0000.
- Full glyph sweep: cycle all 16 patterns through digit 0 across four frames → value nibbles match 0..F in order; the blank pattern on digit 2 gives digit_err=0100 with nibble 0.
- Glitch rejection: a 1-cycle segment change in mid-dwell, or two dwells of only 3 cycles → no capture for that dwell; valid appears only after a full 4-cycle dwell on every digit.
- Illegal anodes: anodes=0000 or 1100 held for 10 cycles → no capture, seen unchanged. Recapturing digit 1 with glyph 9 then glyph A before completion → final nibble A.
- Reset mid-frame: capture digits 0–2, pulse rst_n, then drive all four → valid only after all four post-reset captures; value reflects post-reset data only.
